// File: rtl/video_pkg.sv
// Shared timing types and line/frame length helpers for the video timing generator.
package video_pkg;

  typedef struct packed {
    int active;
    int fp;
    int sync;
    int bp;
  } timing_t;

  localparam timing_t DEF_H = '{active: 320, fp: 16, sync: 32, bp: 48};
  localparam timing_t DEF_V = '{active: 240, fp: 3, sync: 4, bp: 15};

  function automatic int h_total(timing_t t);
    return t.active + t.fp + t.sync + t.bp;
  endfunction

  function automatic int v_total(timing_t t);
    return t.active + t.fp + t.sync + t.bp;
  endfunction

  function automatic int sync_start(timing_t t);
    return t.active + t.fp;
  endfunction

  function automatic int sync_end(timing_t t);
    return t.active + t.fp + t.sync;
  endfunction

endpackage

// File: rtl/video_timing_gen_if.sv
// Framebuffer read port and video output bundle; master is the timing generator.
interface video_timing_gen_if #(
  parameter int ADDR_W = 17
);
  logic              enable;
  logic [ADDR_W-1:0] fb_addr;
  logic              fb_rd;
  logic              fb_data;
  logic              ce_pix;
  logic [7:0]        R;
  logic [7:0]        G;
  logic [7:0]        B;
  logic              HSync;
  logic              VSync;
  logic              HBlank;
  logic              VBlank;
  logic              frame_start;

  modport master (
    input  enable, fb_data,
    output fb_addr, fb_rd, ce_pix, R, G, B, HSync, VSync, HBlank, VBlank, frame_start
  );

  modport slave (
    output enable, fb_data,
    input  fb_addr, fb_rd, ce_pix, R, G, B, HSync, VSync, HBlank, VBlank, frame_start
  );
endinterface

// File: rtl/ce_divider.sv
// Pixel clock-enable divider: ce is combinational, high on the last count of each CE_DIV period.
// Held at zero while disabled, so a re-enable always waits a full period.
module ce_divider #(
  parameter int CE_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic enable,
  output logic ce
);
  localparam int W = (CE_DIV > 2) ? $clog2(CE_DIV) : 1;
  localparam logic [W-1:0] LAST = W'(CE_DIV - 1);

  logic [W-1:0] div;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div <= '0;
    end else if (!enable || div == LAST) begin
      div <= '0;
    end else begin
      div <= div + W'(1);
    end
  end

  assign ce = enable && (div == LAST);
endmodule

// File: rtl/video_timing_gen.sv
// Raster timing generator with 1-bit framebuffer fetch; sync, blank and colour leave aligned
// one pixel after the counters (fb read in the ce cycle, output registered the cycle after).
module video_timing_gen
  import video_pkg::*;
#(
  parameter int          H_ACTIVE = 320,
  parameter int          H_FP     = 16,
  parameter int          H_SYNC   = 32,
  parameter int          H_BP     = 48,
  parameter int          V_ACTIVE = 240,
  parameter int          V_FP     = 3,
  parameter int          V_SYNC   = 4,
  parameter int          V_BP     = 15,
  parameter int          CE_DIV   = 4,
  parameter logic [23:0] ON_RGB   = 24'h101010,
  parameter logic [23:0] OFF_RGB  = 24'hB8C8A0
) (
  input logic               CLK_VIDEO,
  input logic               reset,
  video_timing_gen_if.master vid
);
  localparam timing_t HT = '{active: H_ACTIVE, fp: H_FP, sync: H_SYNC, bp: H_BP};
  localparam timing_t VT = '{active: V_ACTIVE, fp: V_FP, sync: V_SYNC, bp: V_BP};
  localparam int H_TOTAL = h_total(HT);
  localparam int V_TOTAL = v_total(VT);
  localparam int HW      = $clog2(H_TOTAL);
  localparam int VW      = $clog2(V_TOTAL);
  localparam int ADDR_W  = $clog2(H_ACTIVE * V_ACTIVE);

  localparam logic [HW-1:0]     H_LAST = HW'(H_TOTAL - 1);
  localparam logic [VW-1:0]     V_LAST = VW'(V_TOTAL - 1);
  localparam logic [HW-1:0]     H_ACT  = HW'(H_ACTIVE);
  localparam logic [VW-1:0]     V_ACT  = VW'(V_ACTIVE);
  localparam logic [HW-1:0]     H_SS   = HW'(sync_start(HT));
  localparam logic [HW-1:0]     H_SE   = HW'(sync_end(HT));
  localparam logic [VW-1:0]     V_SS   = VW'(sync_start(VT));
  localparam logic [VW-1:0]     V_SE   = VW'(sync_end(VT));
  localparam logic [ADDR_W-1:0] A_LAST = ADDR_W'(H_ACTIVE * V_ACTIVE - 1);

  logic              ce;
  logic [HW-1:0]     h_cnt;
  logic [VW-1:0]     v_cnt;
  logic [ADDR_W-1:0] addr;
  logic              h_wrap;
  logic              v_wrap;
  logic              active;

  // Pixel captured at ce, waiting for its framebuffer data.
  logic ce_d;
  logic p_hb;
  logic p_vb;
  logic p_hs;
  logic p_vs;
  logic p_first;

  logic [23:0] rgb;
  logic        hs;
  logic        vs;
  logic        hb;
  logic        vb;
  logic        fs;

  ce_divider #(.CE_DIV(CE_DIV)) u_ce_divider (
    .clk    (CLK_VIDEO),
    .rst    (reset),
    .enable (vid.enable),
    .ce     (ce)
  );

  assign h_wrap = (h_cnt == H_LAST);
  assign v_wrap = (v_cnt == V_LAST);
  assign active = (h_cnt < H_ACT) && (v_cnt < V_ACT);

  // Address follows the raster by counting, wrapping after the last visible pixel.
  always_ff @(posedge CLK_VIDEO or posedge reset) begin
    if (reset) begin
      h_cnt <= '0;
      v_cnt <= '0;
      addr  <= '0;
    end else if (ce) begin
      if (h_wrap) begin
        h_cnt <= '0;
        v_cnt <= v_wrap ? '0 : v_cnt + VW'(1);
      end else begin
        h_cnt <= h_cnt + HW'(1);
      end
      if (h_wrap && v_wrap) begin
        addr <= '0;
      end else if (active) begin
        addr <= (addr == A_LAST) ? '0 : addr + ADDR_W'(1);
      end
    end
  end

  always_ff @(posedge CLK_VIDEO or posedge reset) begin
    if (reset) begin
      ce_d    <= 1'b0;
      p_hb    <= 1'b1;
      p_vb    <= 1'b1;
      p_hs    <= 1'b0;
      p_vs    <= 1'b0;
      p_first <= 1'b0;
    end else begin
      ce_d <= ce;
      if (ce) begin
        p_hb    <= (h_cnt >= H_ACT);
        p_vb    <= (v_cnt >= V_ACT);
        p_hs    <= (h_cnt >= H_SS) && (h_cnt < H_SE);
        p_vs    <= (v_cnt >= V_SS) && (v_cnt < V_SE);
        p_first <= (h_cnt == '0) && (v_cnt == '0);
      end
    end
  end

  always_ff @(posedge CLK_VIDEO or posedge reset) begin
    if (reset) begin
      rgb <= '0;
      hs  <= 1'b0;
      vs  <= 1'b0;
      hb  <= 1'b1;
      vb  <= 1'b1;
      fs  <= 1'b0;
    end else begin
      fs <= ce_d && p_first;
      if (ce_d) begin
        rgb <= (p_hb || p_vb) ? 24'h0 : (vid.fb_data ? ON_RGB : OFF_RGB);
        hs  <= p_hs;
        vs  <= p_vs;
        hb  <= p_hb;
        vb  <= p_vb;
      end
    end
  end

  assign vid.ce_pix      = ce;
  assign vid.fb_rd       = ce && active;
  assign vid.fb_addr     = addr;
  assign vid.R           = rgb[23:16];
  assign vid.G           = rgb[15:8];
  assign vid.B           = rgb[7:0];
  assign vid.HSync       = hs;
  assign vid.VSync       = vs;
  assign vid.HBlank      = hb;
  assign vid.VBlank      = vb;
  assign vid.frame_start = fs;
endmodule

// File: tb/tb_video_timing_gen.sv
// Reduced-size raster checked cycle by cycle against a pixel-count model, plus literal pins.
module tb_video_timing_gen;
  import video_pkg::*;

  localparam int HA = 16, HF = 2, HS = 3, HB = 4;
  localparam int VA = 8,  VF = 1, VS = 2, VB = 3;
  localparam int CD = 4;
  localparam logic [23:0] ON  = 24'h101010;
  localparam logic [23:0] OFF = 24'hB8C8A0;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int AW = $clog2(HA * VA);

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  bit   chk_on = 1'b0;

  video_timing_gen_if #(.ADDR_W(AW)) vif();

  video_timing_gen #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .CE_DIV(CD), .ON_RGB(ON), .OFF_RGB(OFF)
  ) dut (
    .CLK_VIDEO (clk),
    .reset     (rst),
    .vid       (vif)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: pix = pixel-clock ticks since reset; phase = enabled cycles since the last tick.
  int pix = 0, phase = 0;
  bit pend = 0;
  int pend_h = 0, pend_v = 0;
  logic [23:0] e_rgb = '0;
  bit e_hs = 0, e_vs = 0, e_hb = 1, e_vb = 1, e_fs = 0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      pix = 0; phase = 0; pend = 0;
      e_rgb = '0; e_hs = 0; e_vs = 0; e_hb = 1; e_vb = 1; e_fs = 0;
    end else begin
      e_fs = 0;
      if (pend) begin
        e_hb  = (pend_h >= HA);
        e_vb  = (pend_v >= VA);
        e_hs  = (pend_h >= HA + HF) && (pend_h < HA + HF + HS);
        e_vs  = (pend_v >= VA + VF) && (pend_v < VA + VF + VS);
        e_rgb = (e_hb || e_vb) ? 24'h0 : ((((pend_v * HA + pend_h) % 2) == 1) ? ON : OFF);
        e_fs  = (pend_h == 0) && (pend_v == 0);
      end
      pend = 0;
      if (vif.enable) begin
        if (phase == CD - 1) begin
          pend = 1; pend_h = pix % HT; pend_v = (pix / HT) % VT;
          pix++; phase = 0;
        end else begin
          phase++;
        end
      end else begin
        phase = 0;
      end
    end
  end

  int cmp_h, cmp_v;
  bit cmp_ce, cmp_act;
  always @(negedge clk) begin
    if (chk_on) begin
      cmp_h   = pix % HT;
      cmp_v   = (pix / HT) % VT;
      cmp_ce  = !rst && vif.enable && (phase == CD - 1);
      cmp_act = (cmp_h < HA) && (cmp_v < VA);
      chk("ce_pix", vif.ce_pix, cmp_ce);
      chk("fb_rd", vif.fb_rd, cmp_ce && cmp_act);
      if (cmp_ce && cmp_act) chk("fb_addr", vif.fb_addr, cmp_v * HA + cmp_h);
      chk("rgb", {vif.R, vif.G, vif.B}, e_rgb);
      chk("hsync", vif.HSync, e_hs);
      chk("vsync", vif.VSync, e_vs);
      chk("hblank", vif.HBlank, e_hb);
      chk("vblank", vif.VBlank, e_vb);
      chk("frame_start", vif.frame_start, e_fs);
    end
  end

  // Framebuffer returns addr[0] one cycle after a read, noise otherwise.
  initial begin
    logic rd;
    logic [AW-1:0] a;
    vif.fb_data = 1'b0;
    forever begin
      @(negedge clk);
      rd = vif.fb_rd;
      a  = vif.fb_addr;
      @(posedge clk);
      #1;
      vif.fb_data = rd ? a[0] : 1'($urandom);
    end
  end

  task automatic wait_pos(input int h, input int v, output bit ok);
    ok = 0;
    for (int i = 0; i < 4000 && !ok; i++) begin
      @(negedge clk);
      ok = ((pix % HT) == h) && (((pix / HT) % VT) == v) && (phase == 0);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_ce_pix"}, vif.ce_pix, 0);
    chk({tag, "_fb_rd"}, vif.fb_rd, 0);
    chk({tag, "_fb_addr"}, vif.fb_addr, 0);
    chk({tag, "_rgb"}, {vif.R, vif.G, vif.B}, 0);
    chk({tag, "_sync"}, {vif.HSync, vif.VSync}, 0);
    chk({tag, "_blank"}, {vif.HBlank, vif.VBlank}, 2'b11);
    chk({tag, "_frame_start"}, vif.frame_start, 0);
  endtask

  initial begin
    int n, cyc, hs_cnt, ce_cnt, changes;
    int last_addr;
    bit found, have_last, wrap_seen, ok;
    logic [27:0] snap;

    vif.enable = 1'b0;
    chk("h_total_default", h_total(DEF_H), 416);
    chk("v_total_default", v_total(DEF_V), 262);
    chk("frame_clocks_default", h_total(DEF_H) * v_total(DEF_V) * 4, 435968);

    repeat (2) @(posedge clk);
    #2 chk_on = 1'b1;
    @(negedge clk);
    chk_reset_vals("reset");

    vif.enable = 1'b1;
    @(posedge clk);
    #2 rst = 1'b0;
    n = 0; found = 0;
    while (!found && n < 20) begin @(negedge clk); n++; found = vif.ce_pix; end
    chk("first_ce_cycle", n, 4);
    // Two more cycles: fb read data, then the registered output with frame_start.
    found = 0;
    while (!found && n < 40) begin @(negedge clk); n++; found = vif.frame_start; end
    chk("first_frame_start_cycle", n, 6);
    chk("rgb_pixel_0_0", {vif.R, vif.G, vif.B}, OFF);

    cyc = 0; hs_cnt = 0; ce_cnt = 0; found = 0; have_last = 0; wrap_seen = 0; last_addr = 0;
    while (!found && cyc < 3000) begin
      @(negedge clk);
      cyc++;
      if (cyc == CD) chk("rgb_pixel_1_0", {vif.R, vif.G, vif.B}, ON);
      if (vif.HSync) hs_cnt++;
      if (vif.ce_pix) ce_cnt++;
      if (vif.fb_rd) begin
        if (have_last && vif.fb_addr == 0) begin
          chk("last_addr_before_wrap", last_addr, 127);
          wrap_seen = 1;
        end
        last_addr = int'(vif.fb_addr);
        have_last = 1;
      end
      found = vif.frame_start;
    end
    chk("frame_clocks", cyc, 1400);
    chk("hsync_clocks_per_frame", hs_cnt, 168);
    chk("ce_per_frame", ce_cnt, 350);
    chk("addr_wrap_seen", wrap_seen, 1);

    wait_pos(10, 3, ok);
    chk("reach_gap_pos", ok, 1);
    @(posedge clk);
    #2 vif.enable = 1'b0;
    repeat (2) @(negedge clk);
    snap = {vif.R, vif.G, vif.B, vif.HSync, vif.VSync, vif.HBlank, vif.VBlank};
    ce_cnt = 0; changes = 0;
    repeat (100) begin
      @(negedge clk);
      if (vif.ce_pix) ce_cnt++;
      if ({vif.R, vif.G, vif.B, vif.HSync, vif.VSync, vif.HBlank, vif.VBlank} !== snap) changes++;
    end
    chk("gap_ce_pulses", ce_cnt, 0);
    chk("gap_output_changes", changes, 0);
    @(posedge clk);
    #2 vif.enable = 1'b1;
    n = 0; found = 0;
    while (!found && n < 20) begin @(negedge clk); n++; found = vif.fb_rd; end
    chk("resume_ce_cycle", n, 4);
    chk("resume_addr", vif.fb_addr, 58);

    wait_pos(7, 5, ok);
    chk("reach_reset_pos", ok, 1);
    @(posedge clk);
    #2 rst = 1'b1;
    #1 chk_reset_vals("midframe_reset");
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;
    n = 0; found = 0;
    while (!found && n < 40) begin @(negedge clk); n++; found = vif.frame_start; end
    chk("restart_frame_start_cycle", n, 6);

    repeat (6000) begin
      @(posedge clk);
      #2 vif.enable = ($urandom_range(0, 7) != 0);
    end
    @(posedge clk);
    #2 vif.enable = 1'b1;
    repeat (50) @(posedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
